// File: rtl/types_pkg.sv
// Shared types for the parity FIFO and its downstream pop-side checker.
package types_pkg;

    typedef enum logic {ODD, EVEN} parity_mode_t;

    typedef enum logic {MSB, LSB} parity_bit_choice_t;

    // Occupancy of the checker's main + skid output buffer.
    typedef enum logic [1:0] {EMPTY, ONE, TWO} checker_state_t;

endpackage

// File: rtl/parity_check_unit.sv
// Combinational parity check: splits a word into payload and a bad-parity flag.
module parity_check_unit
    import types_pkg::*;
#(
    parameter int unsigned        DATA_WIDTH        = 8,
    parameter parity_mode_t       PARITY_MODE       = ODD,
    parameter parity_bit_choice_t PARITY_BIT_CHOICE = MSB
) (
    input  logic [DATA_WIDTH-1:0] word,
    output logic [DATA_WIDTH-2:0] payload,
    output logic                  bad
);

    generate
        if (PARITY_BIT_CHOICE == MSB) begin : g_msb
            assign payload = word[DATA_WIDTH-2:0];
        end else begin : g_lsb
            assign payload = word[DATA_WIDTH-1:1];
        end
    endgenerate

    // Parity is over the whole word, parity bit included.
    assign bad = (^word) != (PARITY_MODE == ODD);

endmodule

// File: rtl/pop_parity_checker.sv
// Pop-side parity checker: strips the parity bit, drops or flags bad words,
// and forwards payload through a 2-entry skid buffer with error accounting.
module pop_parity_checker
    import types_pkg::*;
#(
    parameter int unsigned        DATA_WIDTH        = 8,
    parameter parity_mode_t       PARITY_MODE       = ODD,
    parameter parity_bit_choice_t PARITY_BIT_CHOICE = MSB,
    parameter int unsigned        ERR_CNT_WIDTH     = 8,
    parameter bit                 DROP_ON_ERROR     = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid_i,
    input  logic [DATA_WIDTH-1:0]    in_data_i,
    output logic                     in_grant_o,
    output logic                     out_valid_o,
    output logic [DATA_WIDTH-2:0]    out_data_o,
    output logic                     out_err_o,
    input  logic                     out_grant_i,
    output logic [ERR_CNT_WIDTH-1:0] err_count_o,
    output logic                     err_sticky_o,
    input  logic                     err_clear_i
);

    localparam logic [ERR_CNT_WIDTH-1:0] CNT_MAX = '1;

    checker_state_t          state_q, state_d;
    logic [DATA_WIDTH-2:0]   main_data_q, skid_data_q;
    logic                    main_err_q, skid_err_q;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q;
    logic                    sticky_q;

    logic [DATA_WIDTH-2:0]   payload;
    logic                    bad;
    logic                    accept, pop, keep;
    logic                    load_main, load_skid, skid_to_main;

    parity_check_unit #(
        .DATA_WIDTH        (DATA_WIDTH),
        .PARITY_MODE       (PARITY_MODE),
        .PARITY_BIT_CHOICE (PARITY_BIT_CHOICE)
    ) u_check (
        .word    (in_data_i),
        .payload (payload),
        .bad     (bad)
    );

    // Handshakes decode from registered state only, so no grant-to-grant path.
    assign in_grant_o  = (state_q != TWO);
    assign out_valid_o = (state_q != EMPTY);
    assign accept      = in_valid_i && in_grant_o;
    assign pop         = out_valid_o && out_grant_i;
    assign keep        = accept && !(bad && DROP_ON_ERROR);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= EMPTY;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        case (state_q)
            EMPTY: begin
                if (keep) begin
                    state_d   = ONE;
                    load_main = 1'b1;
                end
            end
            ONE: begin
                if (keep && !pop) begin
                    state_d   = TWO;
                    load_skid = 1'b1;
                end else if (!keep && pop) begin
                    state_d = EMPTY;
                end else if (keep && pop) begin
                    load_main = 1'b1;
                end
            end
            TWO: begin
                if (pop) begin
                    state_d      = ONE;
                    skid_to_main = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // With dropping enabled a kept word is never bad, so the stored err stays 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_data_q <= '0;
            main_err_q  <= 1'b0;
            skid_data_q <= '0;
            skid_err_q  <= 1'b0;
        end else begin
            if (load_main) begin
                main_data_q <= payload;
                main_err_q  <= bad;
            end else if (skid_to_main) begin
                main_data_q <= skid_data_q;
                main_err_q  <= skid_err_q;
            end
            if (load_skid) begin
                skid_data_q <= payload;
                skid_err_q  <= bad;
            end
        end
    end

    // A bad accept in the same cycle as a clear counts as the first new error.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt_q <= '0;
            sticky_q  <= 1'b0;
        end else if (accept && bad) begin
            sticky_q <= 1'b1;
            if (err_clear_i)             err_cnt_q <= ERR_CNT_WIDTH'(1);
            else if (err_cnt_q != CNT_MAX) err_cnt_q <= err_cnt_q + ERR_CNT_WIDTH'(1);
        end else if (err_clear_i) begin
            err_cnt_q <= '0;
            sticky_q  <= 1'b0;
        end
    end

    assign out_data_o   = main_data_q;
    assign out_err_o    = main_err_q;
    assign err_count_o  = err_cnt_q;
    assign err_sticky_o = sticky_q;

endmodule

// File: tb/tb_pop_parity_checker.sv
// Two checker instances (drop with 2-bit counter, forward with 8-bit counter)
// share one stimulus stream and are compared against a depth-2 queue model.
module tb_pop_parity_checker;
    import types_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_grant = 1'b0;
    logic       err_clear = 1'b0;

    logic       g [2];
    logic       v [2];
    logic       e [2];
    logic       s [2];
    logic [6:0] d [2];
    logic [1:0] cnt_a;
    logic [7:0] cnt_b;

    int checks = 0;
    int errors = 0;

    // Model: per-instance FIFO contents {err, payload}, occupancy, counter, sticky.
    logic [7:0] mb  [2][2];
    int         mc  [2];
    int         mec [2];
    logic       ms  [2];

    always #5 clk = ~clk;

    pop_parity_checker #(
        .DATA_WIDTH(8), .PARITY_MODE(ODD), .PARITY_BIT_CHOICE(MSB),
        .ERR_CNT_WIDTH(2), .DROP_ON_ERROR(1'b1)
    ) dut_a (
        .clk(clk), .reset_n(reset_n),
        .in_valid_i(in_valid), .in_data_i(in_data), .in_grant_o(g[0]),
        .out_valid_o(v[0]), .out_data_o(d[0]), .out_err_o(e[0]), .out_grant_i(out_grant),
        .err_count_o(cnt_a), .err_sticky_o(s[0]), .err_clear_i(err_clear)
    );

    pop_parity_checker #(
        .DATA_WIDTH(8), .PARITY_MODE(ODD), .PARITY_BIT_CHOICE(MSB),
        .ERR_CNT_WIDTH(8), .DROP_ON_ERROR(1'b0)
    ) dut_b (
        .clk(clk), .reset_n(reset_n),
        .in_valid_i(in_valid), .in_data_i(in_data), .in_grant_o(g[1]),
        .out_valid_o(v[1]), .out_data_o(d[1]), .out_err_o(e[1]), .out_grant_i(out_grant),
        .err_count_o(cnt_b), .err_sticky_o(s[1]), .err_clear_i(err_clear)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mc[i]  = 0;
            mec[i] = 0;
            ms[i]  = 1'b0;
        end
    endtask

    // Applies the rules for the coming edge using the inputs as currently driven.
    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            bit acc, pop, bad, keep;
            int mx;
            mx   = (i == 0) ? 3 : 255;
            acc  = in_valid && (mc[i] < 2);
            pop  = out_grant && (mc[i] > 0);
            bad  = ((^in_data) == 1'b0);
            keep = acc && !(bad && (i == 0));
            if (pop) begin
                mb[i][0] = mb[i][1];
                mc[i]--;
            end
            if (keep) begin
                mb[i][mc[i]] = {bad, in_data[6:0]};
                mc[i]++;
            end
            if (acc && bad) begin
                mec[i] = err_clear ? 1 : ((mec[i] < mx) ? mec[i] + 1 : mx);
                ms[i]  = 1'b1;
            end else if (err_clear) begin
                mec[i] = 0;
                ms[i]  = 1'b0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s[%0d].grant", tag, i), 32'(g[i]), 32'(mc[i] < 2));
            chk($sformatf("%s[%0d].valid", tag, i), 32'(v[i]), 32'(mc[i] > 0));
            if (mc[i] > 0)
                chk($sformatf("%s[%0d].word", tag, i), 32'({e[i], d[i]}), 32'(mb[i][0]));
            chk($sformatf("%s[%0d].count", tag, i),
                (i == 0) ? 32'(cnt_a) : 32'(cnt_b), 32'(mec[i]));
            chk($sformatf("%s[%0d].sticky", tag, i), 32'(s[i]), 32'(ms[i]));
        end
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        chk("reset_data", 32'(d[0]), 32'h0);
        chk("reset_err",  32'(e[1]), 32'h0);
        reset_n = 1'b1;

        // Single good word, full throughput downstream.
        in_valid = 1'b1; in_data = 8'h83; out_grant = 1'b1;
        step("good");
        chk("good_valid", 32'(v[0]), 32'h1);
        chk("good_data",  32'(d[0]), 32'h03);
        in_valid = 1'b0;
        step("good_drain");
        chk("good_gone", 32'(v[0]), 32'h0);

        // Bad word: dropped by A, forwarded with err by B.
        in_valid = 1'b1; in_data = 8'h03;
        step("bad");
        chk("bad_drop_valid", 32'(v[0]), 32'h0);
        chk("bad_drop_count", 32'(cnt_a), 32'h1);
        chk("bad_drop_sticky", 32'(s[0]), 32'h1);
        chk("bad_fwd_word", 32'({e[1], d[1]}), 32'h83);
        in_valid = 1'b0;
        step("bad_drain");

        // Backpressure: two absorbed, third held, then released in order.
        out_grant = 1'b0; in_valid = 1'b1; in_data = 8'h83;
        step("bp1");
        in_data = 8'h85;
        step("bp2");
        chk("bp_grant_low", 32'(g[0]), 32'h0);
        in_data = 8'h86;
        step("bp3");
        chk("bp_hold_data", 32'(d[0]), 32'h03);
        out_grant = 1'b1;
        step("rel1");
        chk("rel1_data", 32'(d[0]), 32'h05);
        step("rel2");
        chk("rel2_data", 32'(d[0]), 32'h06);
        in_valid = 1'b0;
        step("rel3");
        chk("rel3_empty", 32'(v[0]), 32'h0);

        // Counter saturation and clear-with-error.
        err_clear = 1'b1;
        step("clr");
        err_clear = 1'b0; in_valid = 1'b1; in_data = 8'h03;
        repeat (5) step("sat");
        chk("sat_count_a", 32'(cnt_a), 32'h3);
        chk("sat_count_b", 32'(cnt_b), 32'h5);
        err_clear = 1'b1;
        step("clr_bad");
        chk("clr_bad_count", 32'(cnt_a), 32'h1);
        chk("clr_bad_sticky", 32'(s[0]), 32'h1);
        err_clear = 1'b0; in_valid = 1'b0;
        repeat (3) step("drain");

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            out_grant = ($urandom_range(0, 2) != 0);
            err_clear = ($urandom_range(0, 15) == 0);
            step("rand");
        end

        // Asynchronous reset while full.
        err_clear = 1'b0; out_grant = 1'b0; in_valid = 1'b1; in_data = 8'h83;
        step("full1");
        in_data = 8'h85;
        step("full2");
        chk("full_valid", 32'(v[1]), 32'h1);
        chk("full_grant", 32'(g[1]), 32'h0);
        in_valid = 1'b0;
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_valid_a", 32'(v[0]), 32'h0);
        chk("arst_valid_b", 32'(v[1]), 32'h0);
        chk("arst_grant_a", 32'(g[0]), 32'h1);
        chk("arst_grant_b", 32'(g[1]), 32'h1);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1; out_grant = 1'b1;
        repeat (4) step("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
